id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register for the 5-stage MIPS datapath; successor to the plain free-running ID/EX latch.
- Adds a valid bit, stall (hold), flush (squash), and in-block load-use hazard detection with automatic bubble insertion.
- Sits between the register file/control unit outputs and the EX stage.
- Drives a hazard stall request back to the PC and IF/ID registers.

Parameters:
- DATA_W, 32, width of PC+4, read data and sign-extended immediate.
- REG_W, 5, register-address width (rs/rt/rd).
- CTRL_W, 9, width of the packed EX/MEM/WB control bundle excluding memRead and regWrite: regDst, aluOp[2:0], aluSrc, branch, memWrite, memToReg, jump.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- inValid  in  1  ID stage holds a real instruction.
- stall  in  1  downstream freeze; hold all contents.
- flush  in  1  squash the instruction being captured (branch/jump taken).
- pcAdded  in  DATA_W  PC+4.
- read1, read2  in  DATA_W  register-file read data.
- immExt  in  DATA_W  sign-extended instr[15:0].
- rs, rt, rd  in  REG_W  instr[25:21], [20:16], [15:11].
- useRs, useRt  in  1  the ID instruction reads rs / rt.
- memRead, regWrite  in  1  control unit.
- ctrl  in  CTRL_W  remaining control bundle.
- outValid  out  1  EX holds a real instruction.
- outPcAdded, outRead1, outRead2, outImmExt  out  DATA_W  registered copies.
- outRs, outRt, outRd  out  REG_W  registered copies.
- outMemRead, outRegWrite  out  1  registered control.
- outCtrl  out  CTRL_W  registered control bundle.
- hazardStall  out  1  load-use stall request to PC and IF/ID.

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, including outValid; hazardStall is therefore 0. The block leaves reset on the first posedge after rst_n rises.
- hazardStall is combinational from registered state and current inputs. It is 1 when all of the following hold:
  - outValid & outMemRead & inValid
  - outRt != 0
  - (useRs & rs==outRt) | (useRt & rt==outRt)
- Posedge update, in strict priority order:
  - flush=1: outValid, outMemRead, outRegWrite and outCtrl clear to 0; data/address fields clear to 0.
  - else stall=1: all outputs hold. This holds even if hazardStall=1, so the instruction in EX is never lost.
  - else hazardStall=1: insert a bubble, cleared exactly as for flush. Upstream holds IF/ID, so the dependent instruction is re-presented on the next cycle.
  - else load: all fields capture their inputs and outValid<=inValid. If inValid=0, outMemRead, outRegWrite and outCtrl load as 0.
- Latency: 1 cycle, input to output.
- After a bubble, outMemRead=0, so hazardStall drops. A single load-use costs exactly one bubble.
- A load targeting $0 (outRt=0) never raises hazardStall.
- flush together with hazardStall: flush wins; the next cycle re-evaluates with the new state.
- Reset mid-stall: outputs clear immediately; the stall has no effect after reset releases.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds two outputs, bubbleCnt and stallCnt, each CNT_W wide, reset to 0.
  - bubbleCnt increments on each posedge that takes the hazard-bubble branch.
  - stallCnt increments on each posedge with stall=1 and flush=0.
  - Both saturate at all-ones (no wrap).
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: drive all inputs nonzero, pulse rst_n low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Plain load: pcAdded=0x00000014, read1=0x5, rt=8, inValid=1 -> next posedge outPcAdded=0x14, outRead1=5, outRt=8, outValid=1.
- Load-use: EX holds lw with outRt=9, outMemRead=1; ID has rs=9, useRs=1 -> hazardStall=1; next posedge outValid=0 and controls 0; hazardStall then drops and the dependent instruction loads on the following edge.
- Stall priority: stall=1 with new inputs and hazardStall=1 -> outputs unchanged for 3 held cycles.
- Flush and $0: flush=1 with a valid lw input -> outValid=0, outMemRead=0. A load with outRt=0 and rs=0 -> hazardStall=0.
- With ID_EX_PERF_CNT_EN: 3 load-use events and 4 stall cycles -> bubbleCnt=3, stallCnt=4. Force a counter to 0xFFFF and trigger another event -> it stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, stall/flush, and load-use bubble insertion.
// Optional saturating bubble/stall counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 9
`ifdef ID_EX_PERF_CNT_EN
   ,parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] pcAdded,
    input  logic [DATA_W-1:0] read1,
    input  logic [DATA_W-1:0] read2,
    input  logic [DATA_W-1:0] immExt,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic [REG_W-1:0]  rd,
    input  logic              useRs,
    input  logic              useRt,
    input  logic              memRead,
    input  logic              regWrite,
    input  logic [CTRL_W-1:0] ctrl,
    output logic              outValid,
    output logic [DATA_W-1:0] outPcAdded,
    output logic [DATA_W-1:0] outRead1,
    output logic [DATA_W-1:0] outRead2,
    output logic [DATA_W-1:0] outImmExt,
    output logic [REG_W-1:0]  outRs,
    output logic [REG_W-1:0]  outRt,
    output logic [REG_W-1:0]  outRd,
    output logic              outMemRead,
    output logic              outRegWrite,
    output logic [CTRL_W-1:0] outCtrl,
    output logic              hazardStall
`ifdef ID_EX_PERF_CNT_EN
   ,output logic [CNT_W-1:0]  bubbleCnt,
    output logic [CNT_W-1:0]  stallCnt
`endif
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic              mem_rd_q, mem_rd_d, reg_wr_q, reg_wr_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              take_bubble;

    // A load in EX whose destination is read by the ID instruction; $0 never conflicts.
    always_comb begin
        hazardStall = valid_q & mem_rd_q & inValid & (rt_q != '0) &
                      ((useRs & (rs == rt_q)) | (useRt & (rt == rt_q)));
    end

    assign take_bubble = !flush && !stall && hazardStall;

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        mem_rd_d = mem_rd_q;
        reg_wr_d = reg_wr_q;
        ctrl_d   = ctrl_q;
        if (flush || take_bubble) begin
            valid_d  = 1'b0;
            pc_d     = '0;
            rd1_d    = '0;
            rd2_d    = '0;
            imm_d    = '0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
            mem_rd_d = 1'b0;
            reg_wr_d = 1'b0;
            ctrl_d   = '0;
        end else if (!stall) begin
            valid_d  = inValid;
            pc_d     = pcAdded;
            rd1_d    = read1;
            rd2_d    = read2;
            imm_d    = immExt;
            rs_d     = rs;
            rt_d     = rt;
            rd_d     = rd;
            // Side-effecting controls are suppressed for a non-instruction.
            mem_rd_d = memRead & inValid;
            reg_wr_d = regWrite & inValid;
            ctrl_d   = inValid ? ctrl : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            mem_rd_q <= 1'b0;
            reg_wr_q <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            mem_rd_q <= mem_rd_d;
            reg_wr_q <= reg_wr_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign outValid    = valid_q;
    assign outPcAdded  = pc_q;
    assign outRead1    = rd1_q;
    assign outRead2    = rd2_q;
    assign outImmExt   = imm_q;
    assign outRs       = rs_q;
    assign outRt       = rt_q;
    assign outRd       = rd_q;
    assign outMemRead  = mem_rd_q;
    assign outRegWrite = reg_wr_q;
    assign outCtrl     = ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d, stall_cnt_q, stall_cnt_d;

    // Counters saturate rather than wrap.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (take_bubble && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        if (stall && !flush && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubbleCnt = bubble_cnt_q;
    assign stallCnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg; perf-counter checks run
// only when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid, stall, flush;
    logic [31:0] pcAdded, read1, read2, immExt;
    logic [4:0]  rs, rt, rd;
    logic        useRs, useRt, memRead, regWrite;
    logic [8:0]  ctrl;
    logic        outValid;
    logic [31:0] outPcAdded, outRead1, outRead2, outImmExt;
    logic [4:0]  outRs, outRt, outRd;
    logic        outMemRead, outRegWrite;
    logic [8:0]  outCtrl;
    logic        hazardStall;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] bubbleCnt, stallCnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .stall(stall), .flush(flush),
        .pcAdded(pcAdded), .read1(read1), .read2(read2), .immExt(immExt),
        .rs(rs), .rt(rt), .rd(rd), .useRs(useRs), .useRt(useRt),
        .memRead(memRead), .regWrite(regWrite), .ctrl(ctrl),
        .outValid(outValid), .outPcAdded(outPcAdded), .outRead1(outRead1),
        .outRead2(outRead2), .outImmExt(outImmExt), .outRs(outRs), .outRt(outRt),
        .outRd(outRd), .outMemRead(outMemRead), .outRegWrite(outRegWrite),
        .outCtrl(outCtrl), .hazardStall(hazardStall)
`ifdef ID_EX_PERF_CNT_EN
       ,.bubbleCnt(bubbleCnt), .stallCnt(stallCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lw(input logic [31:0] pc, input logic [4:0] dst);
        inValid = 1'b1; pcAdded = pc; rt = dst; rs = 5'd2; rd = 5'd0;
        useRs = 1'b0; useRt = 1'b0; memRead = 1'b1; regWrite = 1'b1; ctrl = 9'h0C3;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, outValid, 0);
        check({tag, "_pc"}, outPcAdded, 0);
        check({tag, "_rd1"}, outRead1, 0);
        check({tag, "_rt"}, outRt, 0);
        check({tag, "_memrd"}, outMemRead, 0);
        check({tag, "_regwr"}, outRegWrite, 0);
        check({tag, "_ctrl"}, outCtrl, 0);
        check({tag, "_haz"}, hazardStall, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        inValid = 1'b1; stall = 1'b0; flush = 1'b0;
        pcAdded = 32'h1234; read1 = 32'h1; read2 = 32'h2; immExt = 32'h3;
        rs = 5'd1; rt = 5'd2; rd = 5'd3; useRs = 1'b1; useRt = 1'b1;
        memRead = 1'b1; regWrite = 1'b1; ctrl = 9'h1FF;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain load
        inValid = 1'b1; pcAdded = 32'h14; read1 = 32'h5; read2 = 32'h77;
        immExt = 32'hFFFF_FFF0; rs = 5'd1; rt = 5'd8; rd = 5'd3;
        useRs = 1'b0; useRt = 1'b0; memRead = 1'b0; regWrite = 1'b1; ctrl = 9'h1A5;
        tick();
        check("load_pc", outPcAdded, 32'h14);
        check("load_rd1", outRead1, 32'h5);
        check("load_rd2", outRead2, 32'h77);
        check("load_imm", outImmExt, 32'hFFFF_FFF0);
        check("load_rt", outRt, 8);
        check("load_rd", outRd, 3);
        check("load_valid", outValid, 1);
        check("load_ctrl", outCtrl, 9'h1A5);
        check("load_regwr", outRegWrite, 1);
        check("load_haz", hazardStall, 0);

        // Load-use: one bubble, then the dependent instruction
        drive_lw(32'h18, 5'd9);
        tick();
        check("lw_memrd", outMemRead, 1);
        check("lw_rt", outRt, 9);
        rs = 5'd9; useRs = 1'b1; rt = 5'd4; useRt = 1'b1; memRead = 1'b0;
        ctrl = 9'h011; pcAdded = 32'h1C; read1 = 32'hAA;
        #1;
        check("lu_haz", hazardStall, 1);
        tick();
        check("bub_valid", outValid, 0);
        check("bub_memrd", outMemRead, 0);
        check("bub_ctrl", outCtrl, 0);
        check("bub_pc", outPcAdded, 0);
        check("bub_haz", hazardStall, 0);
        tick();
        check("dep_valid", outValid, 1);
        check("dep_pc", outPcAdded, 32'h1C);
        check("dep_rs", outRs, 9);
        check("dep_rd1", outRead1, 32'hAA);

        // Stall beats a pending hazard
        drive_lw(32'h20, 5'd10); read1 = 32'h11;
        tick();
        stall = 1'b1; rs = 5'd10; useRs = 1'b1; pcAdded = 32'h24; memRead = 1'b0;
        read1 = 32'h99;
        #1;
        check("st_haz", hazardStall, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_pc", outPcAdded, 32'h20);
            check("st_valid", outValid, 1);
            check("st_memrd", outMemRead, 1);
            check("st_rt", outRt, 10);
            check("st_rd1", outRead1, 32'h11);
        end

        // Flush beats hazard and a valid lw input
        stall = 1'b0; flush = 1'b1; memRead = 1'b1; rt = 5'd5;
        tick();
        flush = 1'b0;
        check("fl_valid", outValid, 0);
        check("fl_memrd", outMemRead, 0);
        check("fl_pc", outPcAdded, 0);

        // Load to $0 never stalls
        drive_lw(32'h30, 5'd0);
        tick();
        check("z_memrd", outMemRead, 1);
        rs = 5'd0; useRs = 1'b1; useRt = 1'b1; memRead = 1'b0;
        #1;
        check("z_haz", hazardStall, 0);

        // Invalid input: fields load, controls forced to 0
        inValid = 1'b0; memRead = 1'b1; regWrite = 1'b1; ctrl = 9'h1FF; pcAdded = 32'h40;
        tick();
        check("inv_valid", outValid, 0);
        check("inv_memrd", outMemRead, 0);
        check("inv_regwr", outRegWrite, 0);
        check("inv_ctrl", outCtrl, 0);
        check("inv_pc", outPcAdded, 32'h40);

        // Asynchronous reset mid-stall
        inValid = 1'b1; stall = 1'b1; pcAdded = 32'h44;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0; memRead = 1'b0; useRs = 1'b0; useRt = 1'b0;
        pcAdded = 32'h48;
        tick();
        check("post_rst_pc", outPcAdded, 32'h48);
        check("post_rst_valid", outValid, 1);

`ifdef ID_EX_PERF_CNT_EN
        check("cnt_rst_b", bubbleCnt, 0);
        for (int k = 0; k < 3; k++) begin
            drive_lw(32'h50, 5'd9);
            tick();
            rs = 5'd9; useRs = 1'b1; memRead = 1'b0;
            tick();
            tick();
        end
        stall = 1'b1;
        repeat (4) tick();
        stall = 1'b0;
        check("cnt_bubble", bubbleCnt, 3);
        check("cnt_stall", stallCnt, 4);
        force dut.bubble_cnt_q = 16'hFFFF;
        #1;
        release dut.bubble_cnt_q;
        drive_lw(32'h60, 5'd9);
        tick();
        rs = 5'd9; useRs = 1'b1; memRead = 1'b0;
        tick();
        check("cnt_sat", bubbleCnt, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
